// File: rtl/uart_rx_ext.sv
// UART receive engine: oversampled deframing with majority-vote bit decisions,
// run-time selectable parity, configurable stop bits and a valid/ready output
// register that reports framing/parity status and drops words on overrun.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | waiting for a falling edge on the synchronised line
// START  | counting to mid start bit; a high line there is a false start
// DATA   | deciding DBIT data bits, LSB first
// PARITY | deciding the parity bit (only when parity was latched as on)
// STOP   | deciding STOP_BITS stop bits, then completing the word
module uart_rx_ext #(
  parameter int DBIT       = 8,
  parameter int OVERSAMPLE = 16,
  parameter int STOP_BITS  = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            sample_tick,
  input  logic            rx,
  input  logic [1:0]      parity_mode,
  output logic [DBIT-1:0] dout,
  output logic            dout_valid,
  input  logic            dout_ready,
  output logic            frame_err,
  output logic            parity_err,
  output logic            overrun,
  output logic            rx_busy
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DBIT);
  localparam logic [CW-1:0] CNT_MID  = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] CNT_V0   = CW'(OVERSAMPLE - 3);
  localparam logic [CW-1:0] CNT_V1   = CW'(OVERSAMPLE - 2);
  localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DBIT - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t          state;
  logic            rx_s1, rx_s2, rx_h;
  logic [CW-1:0]   cnt;
  logic [BW-1:0]   bit_idx;
  logic            stop_idx;
  logic [1:0]      mode_l;
  logic [DBIT-1:0] shreg;
  logic            s0, s1;
  logic            par_acc, par_bad, frm_bad;
  logic            start_edge, vote, par_en;

  assign start_edge = rx_h & ~rx_s2;
  // s0/s1 hold the two earlier samples; the third is the line at decision time
  assign vote       = (s0 & s1) | (s0 & rx_s2) | (s1 & rx_s2);
  assign par_en     = (mode_l == 2'b01) || (mode_l == 2'b10);

  // Synchroniser, deframing FSM and output register in one sequential block
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rx_s1      <= 1'b1;
      rx_s2      <= 1'b1;
      rx_h       <= 1'b1;
      cnt        <= '0;
      bit_idx    <= '0;
      stop_idx   <= 1'b0;
      mode_l     <= 2'b00;
      shreg      <= '0;
      s0         <= 1'b1;
      s1         <= 1'b1;
      par_acc    <= 1'b0;
      par_bad    <= 1'b0;
      frm_bad    <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
      rx_busy    <= 1'b0;
    end else begin
      rx_s1   <= rx;
      rx_s2   <= rx_s1;
      rx_h    <= rx_s2;
      overrun <= 1'b0;
      if (dout_valid && dout_ready) dout_valid <= 1'b0;

      unique case (state)
        IDLE: begin
          if (start_edge) begin
            cnt     <= '0;
            mode_l  <= parity_mode;
            rx_busy <= 1'b1;
            state   <= START;
          end
        end
        START: begin
          if (sample_tick) begin
            if (cnt == CNT_MID) begin
              cnt <= '0;
              if (rx_s2) begin
                rx_busy <= 1'b0;
                state   <= IDLE;
              end else begin
                bit_idx  <= '0;
                stop_idx <= 1'b0;
                par_acc  <= 1'b0;
                par_bad  <= 1'b0;
                frm_bad  <= 1'b0;
                state    <= DATA;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: begin
          if (sample_tick) begin
            if (cnt == CNT_V0) s0 <= rx_s2;
            if (cnt == CNT_V1) s1 <= rx_s2;
            if (cnt != CNT_LAST) begin
              cnt <= cnt + 1'b1;
            end else begin
              cnt <= '0;
              case (state)
                DATA: begin
                  shreg   <= {vote, shreg[DBIT-1:1]};
                  par_acc <= par_acc ^ vote;
                  bit_idx <= bit_idx + 1'b1;
                  if (bit_idx == BIT_LAST) state <= par_en ? PARITY : STOP;
                end
                PARITY: begin
                  // mode_l[1] is 1 for odd parity, flipping the expected XOR
                  par_bad <= par_acc ^ vote ^ mode_l[1];
                  state   <= STOP;
                end
                default: begin
                  if (!vote) frm_bad <= 1'b1;
                  if (stop_idx == STOP_LAST) begin
                    // leave at mid stop bit so a back-to-back start edge is seen
                    rx_busy <= 1'b0;
                    state   <= IDLE;
                    if (!dout_valid || dout_ready) begin
                      dout       <= shreg;
                      frame_err  <= frm_bad | ~vote;
                      parity_err <= par_bad;
                      dout_valid <= 1'b1;
                    end else begin
                      overrun <= 1'b1;
                    end
                  end else begin
                    stop_idx <= stop_idx + 1'b1;
                  end
                end
              endcase
            end
          end
        end
      endcase
    end
  end

endmodule
